// File: rtl/uart_rx_if.sv
// Signal bundle between the 8N1 serial receiver and the logic that consumes its bytes.
// The receiver takes the master side; the consumer takes the slave side.
interface uart_rx_if;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx, rx_ack,
        output rx_data, rx_valid, frame_err, overrun, busy
    );

    modport slave (
        output rx, rx_ack,
        input  rx_data, rx_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversampled deserialiser with a valid/ack holding register,
// framing-error pulse and sticky overrun flag.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.master bus
);
    localparam int         HALF      = CLKS_PER_BIT / 2;
    localparam logic [7:0] LAST      = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t     state, next_state;
    logic       sync1, rx_s;
    logic [7:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;
    logic [7:0] data_q;
    logic       valid_q, overrun_q, ferr_q;
    logic       at_half, at_end;
    logic       sample_bit, byte_done, stop_bad;

    // rx is asynchronous; only the second flop reaches the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.rx;
            rx_s  <= sync1;
        end
    end

    assign at_half = (cnt == HALF_LAST);
    assign at_end  = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!rx_s) next_state = S_START;
            S_START: if (at_half) next_state = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (at_end && idx == 3'd7) next_state = S_STOP;
            S_STOP:  if (at_end) next_state = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        sample_bit = (state == S_DATA) && at_end;
        byte_done  = (state == S_STOP) && at_end && rx_s;
        stop_bad   = (state == S_STOP) && at_end && !rx_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 8'd0;
            idx   <= 3'd0;
            shift <= 8'd0;
        end else begin
            case (state)
                S_START: begin
                    cnt <= at_half ? 8'd0 : cnt + 8'd1;
                    if (at_half) idx <= 3'd0;
                end
                S_DATA, S_STOP: cnt <= at_end ? 8'd0 : cnt + 8'd1;
                default: cnt <= 8'd0;
            endcase
            if (sample_bit) begin
                shift[idx] <= rx_s;
                if (idx != 3'd7) idx <= idx + 3'd1;
            end
        end
    end

    // A completed byte is only accepted if the holding register is free or being freed this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ferr_q <= stop_bad;
            if (byte_done) begin
                if (!valid_q || bus.rx_ack) begin
                    data_q  <= shift;
                    valid_q <= 1'b1;
                    if (bus.rx_ack) overrun_q <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (bus.rx_ack) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised bench for uart_rx: frames are serialised here and the expected
// holding-register state is tracked by a small transaction-level model.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ferr_count = 0;
    int rise_cyc = -1;
    int drive_cyc = 0;
    int ferr0;
    logic prev_valid = 1'b0;

    logic       exp_valid, exp_over;
    logic [7:0] exp_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: counts frame_err cycles and timestamps rx_valid rising
    always @(negedge clk) begin
        if (bus.frame_err) ferr_count = ferr_count + 1;
        if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.rx_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_data"}, 32'(bus.rx_data), 32'(exp_data));
        checkOutput({tag, "_valid"}, 32'(bus.rx_valid), 32'(exp_valid));
        checkOutput({tag, "_overrun"}, 32'(bus.overrun), 32'(exp_over));
    endtask

    // Transaction-level model of the holding register
    task automatic modelComplete(input logic [7:0] b, input bit ack);
        if (!exp_valid || ack) begin
            exp_data  = b;
            exp_valid = 1'b1;
            if (ack) exp_over = 1'b0;
        end else begin
            exp_over = 1'b1;
        end
    endtask

    task automatic ackPulse();
        bus.rx_ack = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
        exp_valid = 1'b0;
        exp_over  = 1'b0;
    endtask

    // Serialise one 8N1 frame; optionally raise rx_ack in the cycle the stop bit is judged
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input bit ack_at_stop);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        drive_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            bus.rx = frame[i];
            for (int j = 0; j < CPB; j++) begin
                if (ack_at_stop && i == 9) bus.rx_ack = (j == HALF + 2);
                tick();
            end
        end
        bus.rx_ack = 1'b0;
        if (stop_bit) modelComplete(b, ack_at_stop);
    endtask

    initial begin
        logic [7:0] rb;
        bus.rx     = 1'b1;
        bus.rx_ack = 1'b0;
        exp_valid  = 1'b0;
        exp_over   = 1'b0;
        exp_data   = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkState("reset");
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_ferr", 32'(bus.frame_err), 32'd0);

        rise_cyc = -1;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkState("a5");
        checkOutput("a5_latency", 32'(rise_cyc - drive_cyc), 32'(2 + 1 + HALF + 9 * CPB));
        ackPulse();
        checkState("a5_ack");
        ackPulse();
        checkState("idle_ack");

        ferr0 = ferr_count;
        bus.rx = 1'b0;
        repeat (3) tick();
        bus.rx = 1'b1;
        repeat (3) tick();
        checkOutput("glitch_busy_hi", 32'(bus.busy), 32'd1);
        repeat (8) tick();
        checkOutput("glitch_busy_lo", 32'(bus.busy), 32'd0);
        checkOutput("glitch_ferr", 32'(ferr_count - ferr0), 32'd0);
        checkState("glitch");

        ferr0 = ferr_count;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        repeat (40) tick();
        checkOutput("break_busy", 32'(bus.busy), 32'd1);
        checkOutput("break_ferr_pulses", 32'(ferr_count - ferr0), 32'd1);
        checkState("break");
        bus.rx = 1'b1;
        repeat (4) tick();
        checkOutput("break_exit", 32'(bus.busy), 32'd0);
        applyStimulus(8'h81, 1'b1, 1'b0);
        checkState("after_break");
        ackPulse();

        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        checkState("overrun");
        ackPulse();
        checkState("overrun_ack");
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b1);
        checkState("ack_at_done");

        bus.rx = 1'b0;
        repeat (CPB) tick();
        bus.rx = 1'b1;
        repeat (4 * CPB + HALF) tick();
        reset = 1'b1;
        #1;
        exp_valid = 1'b0;
        exp_over  = 1'b0;
        exp_data  = 8'h00;
        checkState("async_reset");
        checkOutput("async_reset_busy", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (5 * CPB) tick();
        checkState("partial_frame");
        checkOutput("partial_busy", 32'(bus.busy), 32'd0);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        checkState("after_reset");
        ackPulse();

        for (int k = 0; k < 16; k++) begin
            rb = 8'($urandom);
            repeat ($urandom_range(0, 5)) tick();
            applyStimulus(rb, 1'b1, 1'b0);
            checkState("random");
            if ($urandom_range(0, 1) == 1) ackPulse();
        end
        ackPulse();
        checkState("random_end");

        ferr0 = ferr_count;
        for (int k = 0; k < 256; k++) begin
            applyStimulus(8'(k), 1'b1, 1'b0);
            checkState("loop");
            ackPulse();
        end
        checkOutput("loop_ferr", 32'(ferr_count - ferr0), 32'd0);
        checkOutput("loop_overrun", 32'(bus.overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
